// File: rtl/rv32i_types.sv
// Shared core types: CDB request/broadcast records, functional-unit indices and tag width.
package rv32i_types;

  localparam int unsigned ROB_IDX_W  = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_FU     = 3;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    fu_alu = 2'd0,
    fu_mul = 2'd1,
    fu_mem = 2'd2
  } fu_idx_e;

  typedef struct packed {
    logic                  valid;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  regf_we;
    logic [DATA_W-1:0]     data;
  } cdb_req_t;

  typedef struct packed {
    logic                  valid;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  regf_we;
    logic [DATA_W-1:0]     data;
  } cdb_out_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit request bundle and CDB broadcast bundle around the CDB arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned DATA_W    = 32
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ-1:0][4:0]           req_rd_addr;
  logic [NUM_REQ-1:0]                req_regf_we;
  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0]                req_ready;

  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [4:0]           cdb_rd_addr;
  logic                 cdb_regf_we;
  logic [DATA_W-1:0]    cdb_data;

  // Requester side (functional units) plus the broadcast consumers.
  modport master (
    output req_valid, req_rob_idx, req_rd_addr, req_regf_we, req_data,
    input  req_ready,
    input  cdb_valid, cdb_rob_idx, cdb_rd_addr, cdb_regf_we, cdb_data
  );

  modport slave (
    input  req_valid, req_rob_idx, req_rd_addr, req_regf_we, req_data,
    output req_ready,
    output cdb_valid, cdb_rob_idx, cdb_rd_addr, cdb_regf_we, cdb_data
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    logic [PTR_W-1:0] k;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus with a registered one-cycle broadcast.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_REQ   = NUM_FU,
  parameter int unsigned ROB_IDX_W = rv32i_types::ROB_IDX_W,
  parameter int unsigned DATA_W    = rv32i_types::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  cdb_arbiter_if.slave             bus,
  output logic [NUM_REQ-1:0][15:0] grant_cnt
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]           rr_ptr_d, rr_ptr_q, grant_idx;
  logic [NUM_REQ-1:0]        grant_oh;
  logic                      grant_any, handshake;
  cdb_out_t                  cdb_d, cdb_q;
  logic [NUM_REQ-1:0][15:0]  cnt_d, cnt_q;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PtrW)
  ) u_rr_picker (
    .req  (bus.req_valid),
    .ptr  (rr_ptr_q),
    .grant(grant_oh),
    .idx  (grant_idx),
    .any  (grant_any)
  );

  // Ready is gated by reset so nothing handshakes while the core is held in reset.
  assign bus.req_ready = (rst && !flush) ? grant_oh : '0;
  assign handshake     = grant_any && rst && !flush;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    cnt_d       = cnt_q;
    if (handshake) begin
      cdb_d.valid      = 1'b1;
      cdb_d.rob_idx    = bus.req_rob_idx[grant_idx];
      cdb_d.rd_addr    = bus.req_rd_addr[grant_idx];
      cdb_d.data       = bus.req_data[grant_idx];
      // x0 is hardwired, so a write to it must never reach the register file.
      cdb_d.regf_we    = bus.req_regf_we[grant_idx] && (bus.req_rd_addr[grant_idx] != 5'd0);
      cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
      rr_ptr_d         = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
    end else if (flush) begin
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cdb_valid   = cdb_q.valid;
  assign bus.cdb_rob_idx = cdb_q.rob_idx;
  assign bus.cdb_rd_addr = cdb_q.rd_addr;
  assign bus.cdb_regf_we = cdb_q.regf_we;
  assign bus.cdb_data    = cdb_q.data;
  assign grant_cnt       = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a round-robin model predicts grants and broadcasts.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [N-1:0][15:0] grant_cnt;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .ROB_IDX_W(ROB_IDX_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(
    .NUM_REQ  (N),
    .ROB_IDX_W(ROB_IDX_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .grant_cnt(grant_cnt)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  cdb_out_t    exp_q[$];
  int          m_ptr = 0;
  int unsigned m_cnt[N];
  int          last_g = -1;
  bit          refill = 1'b0;

  task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(int i, logic [4:0] rob, logic [4:0] rd, logic we, logic [31:0] d);
    bus.req_valid[i]   = 1'b1;
    bus.req_rob_idx[i] = rob;
    bus.req_rd_addr[i] = rd;
    bus.req_regf_we[i] = we;
    bus.req_data[i]    = d;
  endtask

  task automatic new_payload(int i);
    set_req(i, 5'($urandom), 5'($urandom), 1'($urandom), $urandom);
  endtask

  // Predict this cycle's grant, compare everything, then advance the model.
  task automatic at_neg();
    logic [N-1:0] exp_ready;
    cdb_out_t     e;
    @(negedge clk);
    exp_ready = '0;
    last_g    = -1;
    if (!rst) begin
      exp_q.delete();
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (!flush) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (last_g < 0 && bus.req_valid[k]) last_g = k;
      end
      if (last_g >= 0) exp_ready[last_g] = 1'b1;
    end
    check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check_eq("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
    for (int i = 0; i < N; i++) check_eq("grant_cnt", 64'(grant_cnt[i]), 64'(m_cnt[i]));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("cdb_valid", 64'(bus.cdb_valid), 64'd1);
      check_eq("cdb_rob_idx", 64'(bus.cdb_rob_idx), 64'(e.rob_idx));
      check_eq("cdb_rd_addr", 64'(bus.cdb_rd_addr), 64'(e.rd_addr));
      check_eq("cdb_regf_we", 64'(bus.cdb_regf_we), 64'(e.regf_we));
      check_eq("cdb_data", 64'(bus.cdb_data), 64'(e.data));
    end else begin
      check_eq("cdb_valid_idle", 64'(bus.cdb_valid), 64'd0);
    end
    if (last_g >= 0) begin
      e.valid   = 1'b1;
      e.rob_idx = bus.req_rob_idx[last_g];
      e.rd_addr = bus.req_rd_addr[last_g];
      e.regf_we = bus.req_regf_we[last_g] && (bus.req_rd_addr[last_g] != 5'd0);
      e.data    = bus.req_data[last_g];
      exp_q.push_back(e);
      m_cnt[last_g] = (m_cnt[last_g] + 1) % 65536;
      m_ptr         = (last_g == N - 1) ? 0 : last_g + 1;
    end else if (rst && flush) begin
      m_ptr = 0;
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
    if (last_g >= 0) begin
      if (refill) new_payload(last_g);
      else bus.req_valid[last_g] = 1'b0;
    end
  endtask

  task automatic tick();
    at_neg();
    to_next();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] rr_seq [6];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    bus.req_valid   = '0;
    bus.req_rob_idx = '0;
    bus.req_rd_addr = '0;
    bus.req_regf_we = '0;
    bus.req_data    = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;

    // Reset holds ready low even with a request present, then idle.
    set_req(int'(fu_mem), 5'd9, 5'd1, 1'b1, 32'h1);
    repeat (2) tick();
    bus.req_valid = '0;
    rst = 1'b1;
    repeat (2) tick();

    // Single ALU result.
    set_req(int'(fu_alu), 5'd3, 5'd5, 1'b1, 32'hDEADBEEF);
    at_neg();
    check_eq("t2_ready", 64'(bus.req_ready), 64'b001);
    to_next();
    at_neg();
    check_eq("t2_valid", 64'(bus.cdb_valid), 64'd1);
    check_eq("t2_tag", 64'(bus.cdb_rob_idx), 64'd3);
    check_eq("t2_rd", 64'(bus.cdb_rd_addr), 64'd5);
    check_eq("t2_we", 64'(bus.cdb_regf_we), 64'd1);
    check_eq("t2_data", 64'(bus.cdb_data), 64'hDEADBEEF);
    to_next();
    at_neg();
    check_eq("t2_valid_off", 64'(bus.cdb_valid), 64'd0);
    to_next();

    // Three continuously valid units rotate from rr_ptr=0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++) new_payload(i);
    refill = 1'b1;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      check_eq("t3_order", 64'(bus.req_ready), 64'(rr_seq[i]));
      if (i > 0) check_eq("t3_b2b_valid", 64'(bus.cdb_valid), 64'd1);
      if (i == 5) refill = 1'b0;
      to_next();
    end
    bus.req_valid = '0;
    at_neg();
    check_eq("t3_last_valid", 64'(bus.cdb_valid), 64'd1);
    for (int i = 0; i < N; i++) check_eq("t3_cnt", 64'(grant_cnt[i]), 64'd2);
    to_next();
    tick();

    // Write to x0 is suppressed; the following cycle flushes while it is on the bus.
    set_req(int'(fu_mul), 5'd7, 5'd0, 1'b1, 32'h12345678);
    tick();
    set_req(int'(fu_mul), 5'd8, 5'd4, 1'b1, 32'hA5A5_0001);
    set_req(int'(fu_mem), 5'd9, 5'd6, 1'b0, 32'hA5A5_0002);
    flush = 1'b1;
    at_neg();
    check_eq("t4_valid", 64'(bus.cdb_valid), 64'd1);
    check_eq("t4_we_x0", 64'(bus.cdb_regf_we), 64'd0);
    check_eq("t4_data", 64'(bus.cdb_data), 64'h12345678);
    check_eq("t5_flush_ready", 64'(bus.req_ready), 64'b000);
    to_next();
    flush = 1'b0;
    at_neg();
    check_eq("t5_valid_off", 64'(bus.cdb_valid), 64'd0);
    check_eq("t5_ptr_cleared", 64'(dut.rr_ptr_q), 64'd0);
    check_eq("t5_mul_first", 64'(bus.req_ready), 64'b010);
    to_next();
    repeat (2) tick();

    // Asynchronous reset while a broadcast is pending and a request is presented.
    set_req(int'(fu_alu), 5'd1, 5'd2, 1'b1, 32'hCAFE);
    tick();
    set_req(int'(fu_mul), 5'd2, 5'd3, 1'b1, 32'hBEEF);
    #2;
    rst = 1'b0;
    at_neg();
    check_eq("rst_async_valid", 64'(bus.cdb_valid), 64'd0);
    bus.req_valid = '0;
    to_next();
    rst = 1'b1;
    tick();

    // Counter wrap on the ALU while the other counters hold their values.
    set_req(int'(fu_mul), 5'd4, 5'd4, 1'b1, 32'h4);
    tick();
    set_req(int'(fu_mem), 5'd5, 5'd5, 1'b1, 32'h5);
    repeat (2) tick();
    new_payload(int'(fu_alu));
    refill = 1'b1;
    repeat (65535) tick();
    at_neg();
    check_eq("t6_cnt0_max", 64'(grant_cnt[0]), 64'hFFFF);
    refill = 1'b0;
    to_next();
    at_neg();
    check_eq("t6_cnt0_wrap", 64'(grant_cnt[0]), 64'd0);
    check_eq("t6_cnt1_hold", 64'(grant_cnt[1]), 64'd1);
    check_eq("t6_cnt2_hold", 64'(grant_cnt[2]), 64'd1);
    to_next();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
